// File: rtl/message_slicer_arbiter_if.sv
// Bundle between the requesters/slicer side and message_slicer_arbiter.
// The arbiter takes the master view; the environment (sources plus slicer) takes the slave view.
interface message_slicer_arbiter_if #(
  parameter int N_SOURCES     = 4,
  parameter int LOG_N_SOURCES = 2,
  parameter int N_SLICES      = 2,
  parameter int WIDTH         = 32
);
  logic [N_SOURCES-1:0]                req;
  logic [N_SOURCES*WIDTH*N_SLICES-1:0] req_data;
  logic [N_SOURCES-1:0]                ack;
  logic [WIDTH*N_SLICES-1:0]           slc_data;
  logic                                slc_nd;
  logic                                slc_out_nd;
  logic [LOG_N_SOURCES-1:0]            grant_id;
  logic                                busy;
  logic                                error;

  modport master (
    input  req, req_data, slc_out_nd,
    output ack, slc_data, slc_nd, grant_id, busy, error
  );

  modport slave (
    output req, req_data, slc_out_nd,
    input  ack, slc_data, slc_nd, grant_id, busy, error
  );
endinterface

// File: rtl/message_slicer_arbiter.sv
// Round-robin arbiter sharing one message_slicer among N_SOURCES requesters, with bounded
// bursts per grant, toggle-style new-data strobe and word credits for the slicer buffer.
module message_slicer_arbiter #(
  parameter int N_SOURCES         = 4,
  parameter int LOG_N_SOURCES     = 2,
  parameter int N_SLICES          = 2,
  parameter int WIDTH             = 32,
  parameter int BUFFER_LENGTH     = 64,
  parameter int LOG_BUFFER_LENGTH = 6,
  parameter int MAX_BURST         = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  message_slicer_arbiter_if.master bus
);
  localparam int MSG_W = WIDTH * N_SLICES;
  localparam int CW    = LOG_BUFFER_LENGTH + 1;
  localparam int SW    = CW + 1;
  localparam int BW    = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT, STALL, RELEASE} state_t;

  state_t                   state, state_next;
  logic [CW-1:0]            credits, credits_next;
  logic [SW-1:0]            credit_sum;
  logic                     overflow;
  logic [LOG_N_SOURCES-1:0] rr_ptr, rr_next;
  logic [LOG_N_SOURCES-1:0] grant_id, grant_next;
  logic [LOG_N_SOURCES-1:0] pick_id;
  logic                     pick_valid;
  logic [BW-1:0]            burst_cnt, burst_inc, burst_next;
  logic [N_SOURCES-1:0]     ack_q, ack_next;
  logic [MSG_W-1:0]         slc_data_q;
  logic                     slc_nd_q;
  logic                     error_q;
  logic                     granted_req;
  logic                     issue;

  function automatic logic [LOG_N_SOURCES-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= N_SOURCES) sum = sum - N_SOURCES;
    return LOG_N_SOURCES'(sum);
  endfunction

  assign granted_req = bus.req[grant_id];
  assign issue       = (state == GRANT) && granted_req &&
                       (credits >= CW'(N_SLICES)) && (burst_cnt < BW'(MAX_BURST));
  assign burst_inc   = burst_cnt + BW'(issue);

  // Issue and return in the same cycle both apply; the sum is one bit wider so a
  // spurious return at a full buffer is seen as overflow rather than wrapping.
  always_comb begin
    credit_sum = {1'b0, credits} + SW'(bus.slc_out_nd);
    if (issue) credit_sum = credit_sum - SW'(N_SLICES);
    overflow     = credit_sum > SW'(BUFFER_LENGTH);
    credits_next = overflow ? CW'(BUFFER_LENGTH) : credit_sum[CW-1:0];
  end

  // Scan from the highest offset down so the first requester at or after rr_ptr wins.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (bus.req[wrap_idx(int'(rr_ptr), i)]) begin
        pick_id    = wrap_idx(int'(rr_ptr), i);
        pick_valid = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_next = grant_id;
    burst_next = burst_inc;
    rr_next    = rr_ptr;
    ack_next   = issue ? (N_SOURCES'(1) << grant_id) : '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_id;
          burst_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!granted_req || (burst_inc == BW'(MAX_BURST))) state_next = RELEASE;
        else if (credits_next < CW'(N_SLICES))             state_next = STALL;
      end
      STALL: begin
        if (!granted_req)                        state_next = RELEASE;
        else if (credits_next >= CW'(N_SLICES))  state_next = GRANT;
      end
      RELEASE: begin
        rr_next    = (grant_id == LOG_N_SOURCES'(N_SOURCES - 1)) ? '0 : grant_id + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register in this block
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      credits    <= CW'(BUFFER_LENGTH);
      rr_ptr     <= '0;
      grant_id   <= '0;
      burst_cnt  <= '0;
      ack_q      <= '0;
      slc_data_q <= '0;
      slc_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state     <= state_next;
      credits   <= credits_next;
      rr_ptr    <= rr_next;
      grant_id  <= grant_next;
      burst_cnt <= burst_next;
      ack_q     <= ack_next;
      if (overflow) error_q <= 1'b1;
      if (issue) begin
        slc_data_q <= bus.req_data[int'(grant_id) * MSG_W +: MSG_W];
        slc_nd_q   <= ~slc_nd_q;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.slc_data = slc_data_q;
  assign bus.slc_nd   = slc_nd_q;
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state == GRANT) || (state == STALL);
  assign bus.error    = error_q;

  credits_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    credits <= CW'(BUFFER_LENGTH));
  ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_q));
endmodule

// File: tb/tb_message_slicer_arbiter.sv
// Scoreboard bench for message_slicer_arbiter: sources and a slicer credit model drive the
// DUT, expected issues are queued at stimulus time and a monitor compares each slc_nd toggle.
module tb_message_slicer_arbiter;
  localparam int N_SOURCES         = 4;
  localparam int LOG_N_SOURCES     = 2;
  localparam int N_SLICES          = 2;
  localparam int WIDTH             = 32;
  localparam int BUFFER_LENGTH     = 64;
  localparam int LOG_BUFFER_LENGTH = 6;
  localparam int MAX_BURST         = 4;
  localparam int MSG_W             = WIDTH * N_SLICES;

  typedef struct {
    logic [LOG_N_SOURCES-1:0] src;
    logic [MSG_W-1:0]         data;
  } exp_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic manual_nd = 1'b0;
  logic auto_nd   = 1'b0;
  bit   auto_ret  = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  int   issued    = 0;
  int   owed      = 0;
  int   base;

  exp_t             exp_q[$];
  logic [MSG_W-1:0] src_q[N_SOURCES][$];

  always #5 clk = ~clk;

  message_slicer_arbiter_if #(
    .N_SOURCES(N_SOURCES), .LOG_N_SOURCES(LOG_N_SOURCES),
    .N_SLICES(N_SLICES), .WIDTH(WIDTH)
  ) bus ();

  assign bus.slc_out_nd = manual_nd | auto_nd;

  message_slicer_arbiter #(
    .N_SOURCES(N_SOURCES), .LOG_N_SOURCES(LOG_N_SOURCES), .N_SLICES(N_SLICES),
    .WIDTH(WIDTH), .BUFFER_LENGTH(BUFFER_LENGTH), .LOG_BUFFER_LENGTH(LOG_BUFFER_LENGTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic offer(input int s, input logic [MSG_W-1:0] d, input bit expect_issue);
    exp_t e;
    src_q[s].push_back(d);
    if (expect_issue) begin
      e.src  = LOG_N_SOURCES'(s);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    for (int s = 0; s < N_SOURCES; s++) src_q[s].delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_issued(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (issued < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, issued, target);
  endtask

  task automatic pulse_nd(input int n);
    @(posedge clk);
    #1 manual_nd = 1'b1;
    repeat (n) @(posedge clk);
    #1 manual_nd = 1'b0;
  endtask

  task automatic do_reset();
    check("pending_expected_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    clear_queues();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Sources: consume on ack, then present the head of their queue before the next edge.
  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N_SOURCES; s++)
        if (rst_n && bus.ack[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
      #1;
      for (int s = 0; s < N_SOURCES; s++) begin
        bus.req[s] = (src_q[s].size() > 0);
        bus.req_data[s*MSG_W +: MSG_W] = (src_q[s].size() > 0) ? src_q[s][0] : '0;
      end
    end
  end

  // Slicer model: each issued message returns N_SLICES one-cycle word strobes.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        owed    = 0;
        auto_nd = 1'b0;
        prev    = 1'b0;
      end else begin
        if (bus.slc_nd !== prev) owed += N_SLICES;
        prev = bus.slc_nd;
        if (auto_ret && owed > 0) begin
          auto_nd = 1'b1;
          owed--;
        end else begin
          auto_nd = 1'b0;
        end
      end
    end
  end

  // Monitor: every slc_nd toggle is one issue and must match the next expected entry.
  initial begin
    logic                 prev;
    exp_t                 e;
    logic [N_SOURCES-1:0] oh;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (bus.slc_nd !== prev) begin
          issued++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue: got src %0d data 0x%0h, expected none",
                     bus.grant_id, bus.slc_data);
          end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.src] = 1'b1;
            check("issue_src", bus.grant_id, e.src);
            check("issue_data", bus.slc_data, e.data);
            check("issue_ack", bus.ack, oh);
          end
        end else if (bus.ack !== '0) begin
          checks++;
          failures++;
          $display("FAIL ack_without_toggle: got ack 0x%0h expected 0x0", bus.ack);
        end
        prev = bus.slc_nd;
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", bus.ack, 0);
    check("rst_slc_data", bus.slc_data, 0);
    check("rst_slc_nd", bus.slc_nd, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single message from source 2.
    offer(2, 64'h0000000B_0000000A, 1'b1);
    wait_issued(1, 20, "t1_issued");
    check("t1_ack", bus.ack, 4'b0100);
    check("t1_slc_nd", bus.slc_nd, 1);
    check("t1_grant_id", bus.grant_id, 2);
    settle(20);
    check("t1_idle_busy", bus.busy, 0);
    check("t1_ack_cleared", bus.ack, 0);
    do_reset();

    // Round-robin over all sources: 0,1,2,3,0 with bursts of MAX_BURST.
    base = issued;
    for (int s = 0; s < N_SOURCES; s++)
      for (int k = 0; k < ((s == 0) ? 8 : 4); k++)
        offer(s, {32'(s), 32'(k)}, 1'b0);
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < MAX_BURST; k++) begin
        exp_t e;
        e.src  = LOG_N_SOURCES'(g % N_SOURCES);
        e.data = {32'(g % N_SOURCES), 32'((g == 4) ? k + 4 : k)};
        exp_q.push_back(e);
      end
    wait_issued(base + 20, 200, "t2_all_issued");
    check("t2_scoreboard_empty", exp_q.size(), 0);
    settle(30);
    check("t2_idle_busy", bus.busy, 0);

    // Credit stall with no slicer returns: 64 words allow exactly 32 messages.
    auto_ret = 1'b0;
    base = issued;
    for (int k = 0; k < 35; k++) offer(0, {32'h3000_0000 + 32'(k), 32'(k)}, k < 34);
    wait_issued(base + 32, 300, "t3_32_issued");
    settle(20);
    check("t3_stalled_count", issued, base + 32);
    check("t3_stalled_busy", bus.busy, 1);
    check("t3_stalled_ack", bus.ack, 0);
    pulse_nd(1);
    settle(10);
    check("t3_one_credit_holds", issued, base + 32);
    // Second return resumes; the strobe stays high into the issue cycle (issue + return).
    pulse_nd(2);
    wait_issued(base + 33, 4, "t3_resume");
    settle(20);
    check("t4_stall_at_one_credit", issued, base + 33);
    check("t4_busy", bus.busy, 1);
    check("t4_no_error", bus.error, 0);
    pulse_nd(1);
    wait_issued(base + 34, 4, "t4_one_more_credit");
    settle(10);
    check("t4_final_count", issued, base + 34);
    do_reset();
    auto_ret = 1'b1;

    // Spurious credit at a full buffer sets the sticky error.
    settle(5);
    check("t5_error_before", bus.error, 0);
    pulse_nd(1);
    check("t5_error_set", bus.error, 1);
    base = issued;
    offer(3, 64'h5555_0003_AAAA_0003, 1'b1);
    wait_issued(base + 1, 20, "t5_traffic");
    check("t5_grant_id", bus.grant_id, 3);
    settle(20);
    check("t5_error_sticky", bus.error, 1);

    // Reset in the middle of a source-1 burst.
    base = issued;
    for (int k = 0; k < 4; k++) offer(1, {32'h6000_0001, 32'(k)}, 1'b1);
    wait_issued(base + 2, 30, "t6_two_issued");
    check("t6_pre_busy", bus.busy, 1);
    check("t6_pre_slc_nd", bus.slc_nd, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", bus.ack, 0);
    check("t6_rst_slc_nd", bus.slc_nd, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_grant_id", bus.grant_id, 0);
    check("t6_rst_error", bus.error, 0);
    clear_queues();
    offer(0, 64'h7000_0000_0000_0070, 1'b1);
    offer(1, 64'h7000_0001_0000_0071, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_issued(base + 3, 20, "t6_first_after_reset");
    check("t6_first_grant", bus.grant_id, 0);
    wait_issued(base + 4, 20, "t6_second_after_reset");
    settle(20);
    check("t6_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/message_slicer_arbiter.md
Name: message_slicer_arbiter

Overview:
Shares one message_slicer between N_SOURCES requesters. Each requester offers one N_SLICES*WIDTH message. The arbiter picks a source round-robin, with a bounded burst per grant, and forwards the message using the slicer's toggle-style new-data convention. It tracks slicer buffer occupancy with a credit counter, so the slicer buffer never overflows. It sits directly upstream of message_slicer: slc_data/slc_nd drive its in_data/in_nd, and its out_nd feeds back into slc_out_nd.

Parameters:
N_SOURCES, 4, number of requesters (>=2)
LOG_N_SOURCES, 2, width of source index
N_SLICES, 2, WIDTH-words per message (must match slicer)
WIDTH, 32, word width (must match slicer)
BUFFER_LENGTH, 64, slicer buffer depth in words (must match slicer)
LOG_BUFFER_LENGTH, 6, log2(BUFFER_LENGTH)
MAX_BURST, 4, max consecutive messages from one source per grant (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_SOURCES  per-source level request; held until ack
req_data  input  N_SOURCES*WIDTH*N_SLICES  source s message at bits [(s+1)*WIDTH*N_SLICES-1 -: WIDTH*N_SLICES]
ack  output  N_SOURCES  one-cycle pulse: message of that source taken this cycle
slc_data  output  WIDTH*N_SLICES  message to slicer in_data
slc_nd  output  1  toggles once per issued message, to slicer in_nd
slc_out_nd  input  1  slicer out_nd; each high cycle returns one word credit
grant_id  output  LOG_N_SOURCES  currently/last granted source
busy  output  1  high in GRANT or STALL
error  output  1  sticky; set on credit overflow

Behaviour:
- Reset (async, rst_n=0): ack=0, slc_data=0, slc_nd=0, grant_id=0, busy=0, error=0, credits=BUFFER_LENGTH, rr_ptr=0, burst_cnt=0, state=IDLE. An in-flight message is dropped with no ack. The slicer must be reset with the same rst_n.
- credits register is LOG_BUFFER_LENGTH+1 bits wide. Each cycle: credits_next = credits - (issue ? N_SLICES : 0) + (slc_out_nd ? 1 : 0). An issue and a return in the same cycle both apply.
- Issue condition: state GRANT, req[grant_id]=1, credits >= N_SLICES, burst_cnt < MAX_BURST. On issue, in the same registered update:
  - slc_data <= req_data slice of grant_id
  - slc_nd <= ~slc_nd
  - ack[grant_id] <= 1
  - burst_cnt++
- Latency: req seen at edge k in GRANT leads to slc_data/slc_nd/ack updated at edge k+1. Up to one message per cycle.
- The ack pulse appears in the same cycle as the slc_nd toggle. A source holding req after ack offers its next message; the source updates req_data on the cycle after ack.
- State machine:
  - IDLE: if any req, grant_id <= first requesting source at or after rr_ptr (wrapping); burst_cnt <= 0; -> GRANT. Else stay.
  - GRANT: if req[grant_id]=0 or burst_cnt==MAX_BURST after this cycle -> RELEASE. Else if credits < N_SLICES (after update) -> STALL. Else stay.
  - STALL: no issue. When credits >= N_SLICES -> GRANT. If req[grant_id] drops -> RELEASE.
  - RELEASE: rr_ptr <= grant_id+1 (wrap at N_SOURCES); -> IDLE. Takes one cycle; no issue.
- Fairness: with all sources requesting, grant order is 0,1,..,N_SOURCES-1,0. Each grant yields up to MAX_BURST messages.
- The ack of the final burst message and the GRANT->RELEASE transition happen on the same edge.
- Credit overflow: if credits_next > BUFFER_LENGTH, error <= 1 (sticky until reset) and credits saturate at BUFFER_LENGTH. This covers spurious slc_out_nd.
- Credits never go negative, because issue requires credits >= N_SLICES.
- busy = (state==GRANT || state==STALL).
- Requests from non-granted sources are ignored; their ack stays 0.

Test Plan:
1. Reset then single source: req[2]=1 with data 0x0000000B_0000000A, held for 1 message. Required: ack[2] one cycle; slc_nd 0->1; slc_data=0x0000000B_0000000A; grant_id=2; credits 64->62; after slicer returns 2 strobes, credits=64.
2. Round-robin: all 4 req held, MAX_BURST=4, no backpressure. Required: 4 acks to source 0, 1 RELEASE gap, 4 to source 1, then 2, 3, 0; slc_nd toggles every issue cycle.
3. Credit stall: slc_out_nd tied 0, source 0 requests continuously, BUFFER_LENGTH=64. Required: exactly 32 messages issued, then state=STALL and no ack. One slc_out_nd pulse does not resume (credits=1). A second pulse resumes; next issue follows within 2 cycles.
4. Simultaneous issue and return: credits=2, issue plus slc_out_nd=1 in the same cycle. Required: credits=1, then STALL, error=0.
5. Spurious credit: at credits=64 (idle), pulse slc_out_nd. Required: error=1 next edge, credits stays 64, error remains after further traffic.
6. Reset mid-burst: assert rst_n=0 during source 1 burst. Required: outputs immediately at reset values (ack=0, slc_nd=0, busy=0); after release, first grant goes to source 0 if requesting.
